// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the MIPS debug read-out path.
// Holds the word geometry, the out_kind tag encodings and the dump FSM
// state type used by state_dump_unit and its word packer.
package mips_dbg_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  // Tag carried with every dumped word so the host can demultiplex the stream.
  localparam logic [1:0] KIND_PC  = 2'd0;
  localparam logic [1:0] KIND_REG = 2'd1;
  localparam logic [1:0] KIND_MEM = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PC_SEND   = 3'd1,
    ST_REG_FETCH = 3'd2,
    ST_REG_SEND  = 3'd3,
    ST_MEM_FETCH = 3'd4,
    ST_MEM_SEND  = 3'd5,
    ST_FIN       = 3'd6
  } dump_state_t;

endpackage

// File: rtl/dump_word_packer.sv
// Byte counter plus big-endian byte-to-word assembly.
// Ports: i_clk/i_reset clock and async reset; i_clr returns the byte counter
//   to 0; i_byte_vld/i_byte_dat present one byte per cycle; o_byte_idx is the
//   position of the byte being presented; o_byte_last flags the final byte;
//   o_word_nxt is the completed word including the byte on i_byte_dat.
// The first byte of a word lands in the MSB: earlier bytes are shifted up as
// later ones arrive, so after the last byte the word is complete without any
// per-position write decoding.
module dump_word_packer
  import mips_dbg_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clr,
  input  logic                  i_byte_vld,
  input  logic [7:0]            i_byte_dat,
  output logic [BYTE_IDX_W-1:0] o_byte_idx,
  output logic                  o_byte_last,
  output logic [WORD_W-1:0]     o_word_nxt
);

  logic [BYTE_IDX_W-1:0] r_byte_idx;
  // Only the bytes still needed after the next shift are stored.
  logic [WORD_W-9:0]     r_word;

  assign o_byte_idx  = r_byte_idx;
  assign o_byte_last = (r_byte_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));
  assign o_word_nxt  = {r_word, i_byte_dat};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_byte_idx <= '0;
      r_word     <= '0;
    end else if (i_clr) begin
      r_byte_idx <= '0;
    end else if (i_byte_vld) begin
      r_byte_idx <= r_byte_idx + 1'b1;
      r_word     <= o_word_nxt[WORD_W-9:0];
    end
  end

endmodule

// File: rtl/state_dump_unit.sv
// Streams final CPU state (PC, register file, a window of data memory) out
// over a valid/ready word interface after a start pulse.
// Ports: i_clk/i_reset clock and async active-high reset; i_start/i_pc_in
//   request and PC snapshot; o_rf_raddr/i_rf_rdata register-file read port;
//   o_dm_addr/i_dm_rdata byte-wide data-memory read port; o_out_valid,
//   i_out_ready, o_out_data, o_out_kind, o_out_index word stream;
//   o_busy/o_done status.
// Each word is fetched into the output register before it is offered, so the
// offered word stays frozen for as long as the sink stalls.
module state_dump_unit
  import mips_dbg_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int NUM_WORDS = 12,
  parameter int DM_BASE   = 0,
  parameter int DM_AW     = 10
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [31:0]       i_pc_in,
  output logic [4:0]        o_rf_raddr,
  input  logic [31:0]       i_rf_rdata,
  output logic [DM_AW-1:0]  o_dm_addr,
  input  logic [7:0]        i_dm_rdata,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [31:0]       o_out_data,
  output logic [1:0]        o_out_kind,
  output logic [5:0]        o_out_index,
  output logic              o_busy,
  output logic              o_done
);

  localparam int RW = (NUM_REGS  > 1) ? $clog2(NUM_REGS)  : 1;
  localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  dump_state_t           r_state;
  dump_state_t           w_state_nxt;

  logic [RW-1:0]         r_reg_idx;
  logic [WW-1:0]         r_word_idx;
  logic [WORD_W-1:0]     r_out_data;
  logic [1:0]            r_out_kind;
  logic [5:0]            r_out_index;

  logic                  w_out_valid;
  logic                  w_busy;
  logic                  w_done;
  logic                  w_reg_last;
  logic                  w_word_last;

  logic [BYTE_IDX_W-1:0] w_byte_idx;
  logic                  w_byte_last;
  logic [WORD_W-1:0]     w_mem_word;
  logic                  w_in_mem_fetch;
  logic [DM_AW-1:0]      w_dm_addr;

  assign w_reg_last     = (r_reg_idx  == RW'(NUM_REGS - 1));
  assign w_word_last    = (r_word_idx == WW'(NUM_WORDS - 1));
  assign w_in_mem_fetch = (r_state == ST_MEM_FETCH);

  // Byte address wraps modulo 2^DM_AW by construction of the sum width.
  assign w_dm_addr = DM_AW'(DM_BASE) + (DM_AW'(r_word_idx) << 2)
                   + DM_AW'(w_byte_idx);

  dump_word_packer u_packer (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clr       (!w_in_mem_fetch),
    .i_byte_vld  (w_in_mem_fetch),
    .i_byte_dat  (i_dm_rdata),
    .o_byte_idx  (w_byte_idx),
    .o_byte_last (w_byte_last),
    .o_word_nxt  (w_mem_word)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (i_start) begin
          w_state_nxt = ST_PC_SEND;
        end
      end
      ST_PC_SEND: begin
        w_out_valid = 1'b1;
        if (i_out_ready) begin
          w_state_nxt = ST_REG_FETCH;
        end
      end
      ST_REG_FETCH: begin
        w_state_nxt = ST_REG_SEND;
      end
      ST_REG_SEND: begin
        w_out_valid = 1'b1;
        if (i_out_ready) begin
          w_state_nxt = w_reg_last ? ST_MEM_FETCH : ST_REG_FETCH;
        end
      end
      ST_MEM_FETCH: begin
        if (w_byte_last) begin
          w_state_nxt = ST_MEM_SEND;
        end
      end
      ST_MEM_SEND: begin
        w_out_valid = 1'b1;
        if (i_out_ready) begin
          w_state_nxt = w_word_last ? ST_FIN : ST_MEM_FETCH;
        end
      end
      ST_FIN: begin
        // busy is already low here; a start seen in this cycle is dropped
        // because the next state is IDLE unconditionally.
        w_busy      = 1'b0;
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_reg_idx   <= '0;
      r_word_idx  <= '0;
      r_out_data  <= '0;
      r_out_kind  <= KIND_PC;
      r_out_index <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_out_data  <= i_pc_in;
            r_out_kind  <= KIND_PC;
            r_out_index <= '0;
          end
        end
        ST_PC_SEND: begin
          if (i_out_ready) begin
            r_reg_idx <= '0;
          end
        end
        ST_REG_FETCH: begin
          r_out_data  <= i_rf_rdata;
          r_out_kind  <= KIND_REG;
          r_out_index <= 6'(r_reg_idx);
        end
        ST_REG_SEND: begin
          if (i_out_ready) begin
            if (w_reg_last) begin
              r_word_idx <= '0;
            end else begin
              r_reg_idx <= r_reg_idx + 1'b1;
            end
          end
        end
        ST_MEM_FETCH: begin
          if (w_byte_last) begin
            r_out_data  <= w_mem_word;
            r_out_kind  <= KIND_MEM;
            r_out_index <= 6'(r_word_idx);
          end
        end
        ST_MEM_SEND: begin
          if (i_out_ready && !w_word_last) begin
            r_word_idx <= r_word_idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Read addresses are only driven while fetching so they sit at 0 otherwise
  // (a nonzero DM_BASE would otherwise leak onto o_dm_addr out of reset).
  assign o_rf_raddr  = (r_state == ST_REG_FETCH) ? 5'(r_reg_idx) : 5'd0;
  assign o_dm_addr   = w_in_mem_fetch ? w_dm_addr : '0;

  assign o_out_valid = w_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_kind  = r_out_kind;
  assign o_out_index = r_out_index;
  assign o_busy      = w_busy;
  assign o_done      = w_done;

endmodule

// File: tb/tb_state_dump_unit.sv
module tb_state_dump_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] pc;

  logic        d0_start, d0_ready, d0_valid, d0_busy, d0_done;
  logic [4:0]  d0_rf_raddr;
  logic [31:0] d0_rf_rdata, d0_data;
  logic [9:0]  d0_dm_addr;
  logic [7:0]  d0_dm_rdata;
  logic [1:0]  d0_kind;
  logic [5:0]  d0_index;

  logic        d1_start, d1_ready, d1_valid, d1_busy, d1_done;
  logic [4:0]  d1_rf_raddr;
  logic [31:0] d1_rf_rdata, d1_data;
  logic [9:0]  d1_dm_addr;
  logic [7:0]  d1_dm_rdata;
  logic [1:0]  d1_kind;
  logic [5:0]  d1_index;

  logic [31:0] rf [32];
  logic [7:0]  dm [1024];

  assign d0_rf_rdata = rf[d0_rf_raddr];
  assign d1_rf_rdata = rf[d1_rf_raddr];
  assign d0_dm_rdata = dm[d0_dm_addr];
  assign d1_dm_rdata = dm[d1_dm_addr];

  state_dump_unit u_dut0 (
    .i_clk(clk), .i_reset(rst), .i_start(d0_start), .i_pc_in(pc),
    .o_rf_raddr(d0_rf_raddr), .i_rf_rdata(d0_rf_rdata),
    .o_dm_addr(d0_dm_addr), .i_dm_rdata(d0_dm_rdata),
    .o_out_valid(d0_valid), .i_out_ready(d0_ready), .o_out_data(d0_data),
    .o_out_kind(d0_kind), .o_out_index(d0_index),
    .o_busy(d0_busy), .o_done(d0_done)
  );

  state_dump_unit #(.DM_BASE(32'h3FC), .DM_AW(10)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_start(d1_start), .i_pc_in(pc),
    .o_rf_raddr(d1_rf_raddr), .i_rf_rdata(d1_rf_rdata),
    .o_dm_addr(d1_dm_addr), .i_dm_rdata(d1_dm_rdata),
    .o_out_valid(d1_valid), .i_out_ready(d1_ready), .o_out_data(d1_data),
    .o_out_kind(d1_kind), .o_out_index(d1_index),
    .o_busy(d1_busy), .o_done(d1_done)
  );

  int errors = 0;
  int checks = 0;

  // Observed stream and reference stream.
  logic [1:0]  q_kind [$];
  logic [5:0]  q_idx  [$];
  logic [31:0] q_data [$];
  int          q_cyc  [$];
  logic [1:0]  exp_k  [$];
  logic [5:0]  exp_i  [$];
  logic [31:0] exp_d  [$];

  int   done_cyc, stab_err, tmo;
  logic valid_c0, busy_c0, busy_c1, busy_done;
  logic done_after, valid_after, busy_after;

  // Reference: PC, then every register, then NUM_WORDS big-endian words read
  // from byte addresses (base + 4j + b) modulo the memory size.
  task automatic build_model(input logic [31:0] pcv, input int base);
    logic [31:0] w;
    exp_k.delete(); exp_i.delete(); exp_d.delete();
    exp_k.push_back(2'd0); exp_i.push_back(6'd0); exp_d.push_back(pcv);
    for (int k = 0; k < 32; k++) begin
      exp_k.push_back(2'd1); exp_i.push_back(6'(k)); exp_d.push_back(rf[k]);
    end
    for (int j = 0; j < 12; j++) begin
      w = 0;
      for (int b = 0; b < 4; b++) w = (w << 8) | 32'(dm[(base + 4*j + b) % 1024]);
      exp_k.push_back(2'd2); exp_i.push_back(6'(j)); exp_d.push_back(w);
    end
  endtask

  // Runs one dump on the selected DUT and records what crossed the interface.
  // rmode: 0 ready always high, 1 pattern 1,0,0,1, 2 random.
  task automatic collect(input int sel, input int rmode, input bit extra);
    logic v, rd, dn, bz, pv, prdy;
    logic [31:0] d, pd;
    logic [1:0]  k, pk;
    logic [5:0]  ix, pix;
    int c;
    q_kind.delete(); q_idx.delete(); q_data.delete(); q_cyc.delete();
    done_cyc = -1; stab_err = 0; tmo = 1; pv = 0; prdy = 1;
    pd = 0; pk = 0; pix = 0;
    c = 0;
    @(negedge clk);
    while (c < 3000) begin
      case (rmode)
        0: rd = 1'b1;
        1: rd = ((c % 4) == 0) || ((c % 4) == 3);
        default: rd = ($urandom_range(0, 2) != 0);
      endcase
      if (sel == 1) begin
        d1_start = (c == 0) || (extra && (c == 10 || c == 126));
        d1_ready = rd;
      end else begin
        d0_start = (c == 0) || (extra && (c == 10 || c == 126));
        d0_ready = rd;
      end
      #1;
      v  = sel ? d1_valid : d0_valid;
      d  = sel ? d1_data  : d0_data;
      k  = sel ? d1_kind  : d0_kind;
      ix = sel ? d1_index : d0_index;
      dn = sel ? d1_done  : d0_done;
      bz = sel ? d1_busy  : d0_busy;
      if (c == 0) begin valid_c0 = v; busy_c0 = bz; end
      if (c == 1) busy_c1 = bz;
      if (pv && !prdy && (!v || d !== pd || k !== pk || ix !== pix)) stab_err++;
      if (v && rd) begin
        q_kind.push_back(k); q_idx.push_back(ix); q_data.push_back(d); q_cyc.push_back(c);
      end
      if (dn) begin
        done_cyc = c; busy_done = bz; tmo = 0;
        break;
      end
      pv = v; prdy = rd; pd = d; pk = k; pix = ix;
      @(negedge clk);
      c++;
    end
    @(posedge clk);
    #1;
    done_after  = sel ? d1_done  : d0_done;
    valid_after = sel ? d1_valid : d0_valid;
    busy_after  = sel ? d1_busy  : d0_busy;
    d0_start = 0; d1_start = 0;
  endtask

  task automatic fill_basic();
    for (int k = 0; k < 32; k++) rf[k] = 32'(k) * 32'h11111111;
    for (int i = 0; i < 1024; i++) dm[i] = 8'(i);
  endtask

  task automatic test_reset();
    rst = 1; d0_start = 0; d1_start = 0; d0_ready = 0; d1_ready = 0; pc = 0;
    #2;
    checks++;
    if ({d0_valid, d0_busy, d0_done, d0_data, d0_kind, d0_index, d0_rf_raddr, d0_dm_addr} !== '0) begin
      errors++;
      $display("FAIL reset_dut0: valid=%b busy=%b done=%b data=%h kind=%0d idx=%0d ra=%0d da=%h, required all 0",
               d0_valid, d0_busy, d0_done, d0_data, d0_kind, d0_index, d0_rf_raddr, d0_dm_addr);
    end
    checks++;
    if ({d1_valid, d1_busy, d1_done, d1_data, d1_kind, d1_index, d1_rf_raddr, d1_dm_addr} !== '0) begin
      errors++;
      $display("FAIL reset_dut1: valid=%b busy=%b dm_addr=%h, required all 0", d1_valid, d1_busy, d1_dm_addr);
    end
    @(negedge clk); @(negedge clk);
    rst = 0;
  endtask

  task automatic test_basic();
    fill_basic();
    pc = 32'h0000004C;
    build_model(pc, 0);
    collect(0, 0, 0);
    checks++; if (tmo != 0) begin errors++; $display("FAIL basic_timeout: no done seen"); end
    checks++; if (q_data.size() != 45) begin errors++; $display("FAIL basic_count: got %0d words, required 45", q_data.size()); end
    checks++; if ({valid_c0, busy_c0} !== 2'b00) begin errors++; $display("FAIL basic_idle: valid=%b busy=%b at cycle 0, required 0 0", valid_c0, busy_c0); end
    checks++; if (busy_c1 !== 1'b1) begin errors++; $display("FAIL basic_busy_c1: got %b required 1", busy_c1); end
    checks++; if (done_cyc != 126) begin errors++; $display("FAIL basic_done_cycle: got %0d required 126", done_cyc); end
    checks++; if (busy_done !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b required 0", busy_done); end
    checks++; if ({done_after, busy_after} !== 2'b00) begin errors++; $display("FAIL basic_done_pulse: done=%b busy=%b after, required 0 0", done_after, busy_after); end
    if (q_data.size() == 45) begin
      checks++; if (q_cyc[0] != 1) begin errors++; $display("FAIL basic_pc_cycle: got %0d required 1", q_cyc[0]); end
      checks++; if (q_cyc[32] != 65) begin errors++; $display("FAIL basic_reg31_cycle: got %0d required 65", q_cyc[32]); end
      checks++; if (q_cyc[44] != 125) begin errors++; $display("FAIL basic_mem11_cycle: got %0d required 125", q_cyc[44]); end
      checks++; if (q_kind[0] !== 2'd0 || q_data[0] !== 32'h0000004C) begin errors++; $display("FAIL basic_pc: kind=%0d data=%h required 0 0000004c", q_kind[0], q_data[0]); end
      checks++; if (q_kind[6] !== 2'd1 || q_idx[6] !== 6'd5 || q_data[6] !== 32'h55555555) begin errors++; $display("FAIL basic_reg5: kind=%0d idx=%0d data=%h required 1 5 55555555", q_kind[6], q_idx[6], q_data[6]); end
      checks++; if (q_kind[35] !== 2'd2 || q_idx[35] !== 6'd2 || q_data[35] !== 32'h08090A0B) begin errors++; $display("FAIL basic_mem2: kind=%0d idx=%0d data=%h required 2 2 08090a0b", q_kind[35], q_idx[35], q_data[35]); end
    end
    for (int i = 0; i < exp_d.size() && i < q_data.size(); i++) begin
      checks++;
      if (q_kind[i] !== exp_k[i] || q_idx[i] !== exp_i[i] || q_data[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL basic_seq word %0d: got k=%0d i=%0d d=%h required k=%0d i=%0d d=%h", i, q_kind[i], q_idx[i], q_data[i], exp_k[i], exp_i[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    fill_basic();
    pc = 32'h0000004C;
    build_model(pc, 0);
    collect(0, 1, 0);
    checks++; if (tmo != 0) begin errors++; $display("FAIL bp_timeout: no done seen"); end
    checks++; if (q_data.size() != 45) begin errors++; $display("FAIL bp_count: got %0d words, required 45", q_data.size()); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL bp_stable: %0d unstable stall cycles, required 0", stab_err); end
    for (int i = 0; i < exp_d.size() && i < q_data.size(); i++) begin
      checks++;
      if (q_kind[i] !== exp_k[i] || q_idx[i] !== exp_i[i] || q_data[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL bp_seq word %0d: got k=%0d i=%0d d=%h required k=%0d i=%0d d=%h", i, q_kind[i], q_idx[i], q_data[i], exp_k[i], exp_i[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_endian();
    fill_basic();
    dm[0] = 8'hDE; dm[1] = 8'hAD; dm[2] = 8'hBE; dm[3] = 8'hEF;
    pc = 32'h00400000;
    collect(0, 0, 0);
    checks++;
    if (q_data.size() < 34 || q_kind[33] !== 2'd2 || q_idx[33] !== 6'd0 || q_data[33] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL endian_mem0: size=%0d data=%h required deadbeef", q_data.size(), (q_data.size() > 33) ? q_data[33] : 32'h0);
    end
  endtask

  task automatic test_wrap();
    fill_basic();
    pc = 32'h12345678;
    build_model(pc, 32'h3FC);
    collect(1, 0, 0);
    checks++; if (q_data.size() != 45) begin errors++; $display("FAIL wrap_count: got %0d words, required 45", q_data.size()); end
    if (q_data.size() == 45) begin
      checks++; if (q_data[33] !== 32'hFCFDFEFF) begin errors++; $display("FAIL wrap_mem0: got %h required fcfdfeff", q_data[33]); end
      checks++; if (q_data[34] !== 32'h00010203) begin errors++; $display("FAIL wrap_mem1: got %h required 00010203", q_data[34]); end
    end
    for (int i = 0; i < exp_d.size() && i < q_data.size(); i++) begin
      checks++;
      if (q_kind[i] !== exp_k[i] || q_idx[i] !== exp_i[i] || q_data[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL wrap_seq word %0d: got k=%0d i=%0d d=%h required k=%0d i=%0d d=%h", i, q_kind[i], q_idx[i], q_data[i], exp_k[i], exp_i[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    int bad;
    fill_basic();
    pc = 32'h0000ABCC;
    found = 0;
    @(negedge clk);
    d0_start = 1; d0_ready = 1;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (d0_valid && d0_kind == 2'd1 && d0_index == 6'd7) begin
        d0_ready = 0;
        found = 1;
        break;
      end
      @(negedge clk);
      d0_start = 0;
    end
    d0_start = 0;
    checks++; if (!found) begin errors++; $display("FAIL rstmid_reach: reg 7 never offered, required offered"); end
    #1 rst = 1;
    #1;
    checks++;
    if ({d0_valid, d0_busy, d0_done, d0_data, d0_kind, d0_index, d0_rf_raddr, d0_dm_addr} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: valid=%b busy=%b done=%b data=%h kind=%0d idx=%0d, required all 0",
               d0_valid, d0_busy, d0_done, d0_data, d0_kind, d0_index);
    end
    @(negedge clk); @(negedge clk);
    rst = 0; d0_ready = 1;
    bad = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk); #1;
      if (d0_done || d0_valid || d0_busy) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_quiet: %0d active cycles after reset, required 0", bad); end
    build_model(pc, 0);
    collect(0, 0, 0);
    checks++; if (q_data.size() != 45) begin errors++; $display("FAIL rstmid_count: got %0d words, required 45", q_data.size()); end
    for (int i = 0; i < exp_d.size() && i < q_data.size(); i++) begin
      checks++;
      if (q_kind[i] !== exp_k[i] || q_idx[i] !== exp_i[i] || q_data[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL rstmid_seq word %0d: got k=%0d i=%0d d=%h required k=%0d i=%0d d=%h", i, q_kind[i], q_idx[i], q_data[i], exp_k[i], exp_i[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int bad;
    fill_basic();
    pc = 32'h00000100;
    build_model(pc, 0);
    collect(0, 0, 1);
    checks++; if (q_data.size() != 45) begin errors++; $display("FAIL ign_count: got %0d words, required 45", q_data.size()); end
    checks++; if (done_cyc != 126) begin errors++; $display("FAIL ign_done_cycle: got %0d required 126", done_cyc); end
    checks++; if ({valid_after, busy_after} !== 2'b00) begin errors++; $display("FAIL ign_restart: valid=%b busy=%b after done, required 0 0", valid_after, busy_after); end
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (d0_valid || d0_busy) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ign_quiet: %0d active cycles, required 0", bad); end
    for (int i = 0; i < exp_d.size() && i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== exp_d[i] || q_kind[i] !== exp_k[i]) begin
        errors++;
        $display("FAIL ign_seq word %0d: got %h required %h", i, q_data[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < 32; k++) rf[k] = $urandom;
      for (int i = 0; i < 1024; i++) dm[i] = 8'($urandom);
      pc = $urandom;
      build_model(pc, (it == 1) ? 32'h3FC : 0);
      collect((it == 1) ? 1 : 0, 2, 0);
      checks++; if (q_data.size() != 45) begin errors++; $display("FAIL rand_count it%0d: got %0d required 45", it, q_data.size()); end
      checks++; if (stab_err != 0) begin errors++; $display("FAIL rand_stable it%0d: got %0d required 0", it, stab_err); end
      for (int i = 0; i < exp_d.size() && i < q_data.size(); i++) begin
        checks++;
        if (q_kind[i] !== exp_k[i] || q_idx[i] !== exp_i[i] || q_data[i] !== exp_d[i]) begin
          errors++;
          $display("FAIL rand_seq it%0d word %0d: got k=%0d i=%0d d=%h required k=%0d i=%0d d=%h", it, i, q_kind[i], q_idx[i], q_data[i], exp_k[i], exp_i[i], exp_d[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_endian();
    test_wrap();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/state_dump_unit.md
Name: state_dump_unit

Overview:
Synthesizable read-out engine for the single-cycle MIPS core. It is the hardware counterpart of the bench-side memory preload. On a start pulse it streams the final CPU state over a valid/ready word interface to a host or debug link, in this order: the PC, the 32 register-file entries, then NUM_WORDS big-endian words assembled from the byte-addressed data memory. It sits beside the CPU and uses a spare combinational read port on the register file and on data memory.

Parameters:
NUM_REGS, 32, register-file entries dumped (index width 5)
NUM_WORDS, 12, data-memory words dumped
DM_BASE, 0, byte address of the first dumped word
DM_AW, 10, data-memory byte-address width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to begin a dump; ignored while busy
pc_in  in  32  CPU program counter, sampled on accepted start
rf_raddr  out  5  register-file read address
rf_rdata  in  32  register-file read data, combinational from rf_raddr
dm_addr  out  DM_AW  data-memory byte address
dm_rdata  in  8  data-memory byte, combinational from dm_addr
out_valid  out  1  out_data/out_kind/out_index hold a word
out_ready  in  1  sink accepts the word when out_valid && out_ready
out_data  out  32  dumped word
out_kind  out  2  0=PC, 1=REG, 2=MEM
out_index  out  6  register index or memory word index (0 for PC)
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (asynchronous, any time, including mid-dump): FSM goes to IDLE. All outputs are 0: out_valid, busy, done, out_data, out_kind, out_index, rf_raddr, dm_addr. A dump in progress is abandoned, with no partial done.
- FSM states: IDLE, PC_SEND, REG_FETCH, REG_SEND, MEM_FETCH, MEM_SEND, FIN.
- IDLE: when start=1, latch pc_in into out_data, set kind=0 and index=0, and go to PC_SEND. busy rises on the next cycle.
- PC_SEND: out_valid=1. On handshake, set reg counter r=0 and go to REG_FETCH.
- REG_FETCH (1 cycle): rf_raddr=r. Capture rf_rdata into out_data with kind=1 and index=r, then go to REG_SEND.
- REG_SEND: out_valid=1. On handshake, go to REG_FETCH with r+1. If r==NUM_REGS-1, instead go to MEM_FETCH with word counter w=0 and byte counter b=0.
- MEM_FETCH (4 cycles): dm_addr = DM_BASE + 4w + b, for b=0..3. Byte b is written into out_data[31-8b -: 8], so byte 0 is the MSB. After b=3, set kind=2 and index=w, then go to MEM_SEND.
- MEM_SEND: out_valid=1. On handshake, go to MEM_FETCH with w+1 and b=0. If w==NUM_WORDS-1, go to FIN instead.
- FIN (1 cycle): done=1 and busy=0 on the following cycle. Then return to IDLE.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_kind and out_index hold stable. out_valid never drops without a handshake.
- Counters: address arithmetic is modulo 2^DM_AW, so a dump wraps around the top of data memory. r and w are sized to their parameter maxima and never overflow in normal operation.
- start while busy has no effect. start asserted in the same cycle as done is ignored; a new dump begins only from IDLE.
- Latency with out_ready held high, start sampled at edge 0:
  - PC valid in cycle 1.
  - reg i valid in cycle 3+2i (reg 31 in cycle 65).
  - mem word j valid in cycle 70+5j (word 11 in cycle 125).
  - done in cycle 126.
- Back-pressure adds cycles only in the *_SEND states.

Decomposition:
- Shared package mips_dbg_pkg holds:
  - the out_kind encodings KIND_PC/KIND_REG/KIND_MEM;
  - the FSM state enum;
  - WORD_W=32 and BYTES_PER_WORD=4.
- Optional sub-module dump_word_packer: byte counter plus the 4-byte big-endian shift into a 32-bit word, reused later by a matching loader.

Test Plan:
- Basic order, full dump: pc_in=0x0000004C, R[k]=k*0x11111111, DM bytes i=i, out_ready=1.
  - First word is kind=0, data=0x0000004C.
  - Reg 5 is kind=1, data=0x55555555.
  - Mem word 2 is kind=2, data=0x08090A0B.
  - 45 words total; done in cycle 126.
- Back-pressure: out_ready toggles 1,0,0,1 repeatedly -> the word sequence is identical to the basic test, data stays stable during stalls, and no word is duplicated or dropped.
- DM_BASE=0x3FC, DM_AW=10 -> mem word 1 reads bytes 0x000..0x003, showing wrap-around.
- Reset mid-dump: assert reset during REG_SEND of reg 7 -> outputs go to 0 immediately and no done pulse occurs. A later start produces a clean dump beginning with the PC.
- start pulsed while busy, and again coincident with done -> ignored; exactly one dump is produced.
- Endianness: DM bytes 0..3 = DE AD BE EF -> mem word 0 = 0xDEADBEEF.
